// File: rtl/onehot_decoder_seq_if.sv
// Command/status bundle for onehot_decoder_seq.
// Optional mask input is present when ONEHOT_DECODER_SEQ_MASK_EN is defined.
interface onehot_decoder_seq_if #(
    parameter int SEL_W = 2,
    parameter int DW_W  = 8
);
    localparam int OUT_W = 1 << SEL_W;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [SEL_W-1:0] cmd_sel;
    logic [DW_W-1:0]  cmd_dwell;
    logic             en;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             active;
    logic             done;

`ifdef ONEHOT_DECODER_SEQ_MASK_EN
    logic [OUT_W-1:0] mask;

    modport master (
        output cmd_valid, cmd_mode, cmd_sel, cmd_dwell, en, mask,
        input  cmd_ready, out, idx, active, done
    );
    modport slave (
        input  cmd_valid, cmd_mode, cmd_sel, cmd_dwell, en, mask,
        output cmd_ready, out, idx, active, done
    );
`else
    modport master (
        output cmd_valid, cmd_mode, cmd_sel, cmd_dwell, en,
        input  cmd_ready, out, idx, active, done
    );
    modport slave (
        input  cmd_valid, cmd_mode, cmd_sel, cmd_dwell, en,
        output cmd_ready, out, idx, active, done
    );
`endif
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with HOLD / SCAN / SWEEP sequencing behind a valid/ready command.
// Define ONEHOT_DECODER_SEQ_MASK_EN to add a live skip-mask for SCAN/SWEEP stepping.
module onehot_decoder_seq #(
    parameter int SEL_W   = 2,
    parameter int DW_W    = 8,
    parameter int OUT_POL = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    onehot_decoder_seq_if.slave bus
);
    localparam int OUT_W = 1 << SEL_W;
    localparam logic [OUT_W-1:0] OFF_PAT  = (OUT_POL != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    localparam logic [DW_W-1:0]  DW_ONE   = {{(DW_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       MODE_HOLD  = 2'b00;
    localparam logic [1:0]       MODE_SCAN  = 2'b01;
    localparam logic [1:0]       MODE_SWEEP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_SCAN  = 2'b10,
        ST_SWEEP = 2'b11
    } state_t;

    state_t           state_r;
    logic [SEL_W-1:0] idx_r;
    logic [DW_W-1:0]  cnt_r;
    logic [DW_W-1:0]  dwell_r;
    logic [OUT_W-1:0] out_r;
    logic             active_r;
    logic             done_r;

    logic [OUT_W-1:0] mask_s;
    logic             accept_s;
    logic             dwell_end_s;
    logic [DW_W-1:0]  dwell_eff_s;
    logic [SEL_W:0]   scan_start_s;
    logic [SEL_W:0]   sweep_start_s;
    logic [SEL_W:0]   scan_step_s;
    logic [SEL_W:0]   sweep_step_s;

    // Returns {found, index}: lowest unmasked index above start (or at it when incl).
    function automatic logic [SEL_W:0] find_up(input logic [OUT_W-1:0] m,
                                               input logic [SEL_W-1:0] start,
                                               input logic incl);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            if (!m[i] && ((i > int'(start)) || (incl && (i == int'(start))))) begin
                r = {1'b1, i[SEL_W-1:0]};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Same search, but falls back to the lowest unmasked index (wrap-around).
    function automatic logic [SEL_W:0] find_wrap(input logic [OUT_W-1:0] m,
                                                 input logic [SEL_W-1:0] start,
                                                 input logic incl);
        logic [SEL_W:0] r;
        r = find_up(m, start, incl);
        if (!r[SEL_W]) begin
            for (int i = OUT_W - 1; i >= 0; i--) begin
                if (!m[i]) begin
                    r = {1'b1, i[SEL_W-1:0]};
                end else begin
                    r = r;
                end
            end
        end else begin
            r = r;
        end
        return r;
    endfunction

    function automatic logic [OUT_W-1:0] drive(input logic on, input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        if (!on) begin
            v = OFF_PAT;
        end else if (OUT_POL != 0) begin
            v = ~v;
        end else begin
            v = v;
        end
        return v;
    endfunction

`ifdef ONEHOT_DECODER_SEQ_MASK_EN
    assign mask_s = bus.mask;
`else
    assign mask_s = {OUT_W{1'b0}};
`endif

    assign bus.cmd_ready = (state_r != ST_SWEEP);
    assign accept_s      = bus.cmd_valid && (state_r != ST_SWEEP);
    assign dwell_eff_s   = (bus.cmd_dwell == {DW_W{1'b0}}) ? DW_ONE : bus.cmd_dwell;
    assign dwell_end_s   = (cnt_r == (dwell_r - DW_ONE));
    assign scan_start_s  = find_wrap(mask_s, bus.cmd_sel, 1'b1);
    assign sweep_start_s = find_up(mask_s, bus.cmd_sel, 1'b1);
    assign scan_step_s   = find_wrap(mask_s, idx_r, 1'b0);
    assign sweep_step_s  = find_up(mask_s, idx_r, 1'b0);

    assign bus.out    = out_r;
    assign bus.idx    = idx_r;
    assign bus.active = active_r;
    assign bus.done   = done_r;

    // Sequencer FSM: command acceptance, dwell counting, stepping and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            cnt_r    <= '0;
            dwell_r  <= DW_ONE;
            out_r    <= OFF_PAT;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                cnt_r   <= '0;
                dwell_r <= dwell_eff_s;
                case (bus.cmd_mode)
                    MODE_HOLD: begin
                        state_r  <= ST_HOLD;
                        idx_r    <= bus.cmd_sel;
                        active_r <= 1'b1;
                        out_r    <= drive(bus.en, bus.cmd_sel);
                    end
                    MODE_SCAN: begin
                        if (scan_start_s[SEL_W]) begin
                            state_r  <= ST_SCAN;
                            idx_r    <= scan_start_s[SEL_W-1:0];
                            active_r <= 1'b1;
                            out_r    <= drive(bus.en, scan_start_s[SEL_W-1:0]);
                        end else begin
                            state_r  <= ST_IDLE;
                            active_r <= 1'b0;
                            out_r    <= OFF_PAT;
                        end
                    end
                    MODE_SWEEP: begin
                        if (sweep_start_s[SEL_W]) begin
                            state_r  <= ST_SWEEP;
                            idx_r    <= sweep_start_s[SEL_W-1:0];
                            active_r <= 1'b1;
                            out_r    <= drive(bus.en, sweep_start_s[SEL_W-1:0]);
                        end else begin
                            // Nothing left to visit: the sweep is already complete.
                            state_r  <= ST_IDLE;
                            active_r <= 1'b0;
                            out_r    <= OFF_PAT;
                            done_r   <= 1'b1;
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        active_r <= 1'b0;
                        out_r    <= OFF_PAT;
                    end
                endcase
            end else begin
                case (state_r)
                    ST_HOLD: begin
                        out_r <= drive(bus.en, idx_r);
                    end
                    ST_SCAN: begin
                        if (!dwell_end_s) begin
                            cnt_r <= cnt_r + DW_ONE;
                            out_r <= drive(bus.en, idx_r);
                        end else if (scan_step_s[SEL_W]) begin
                            cnt_r <= '0;
                            idx_r <= scan_step_s[SEL_W-1:0];
                            out_r <= drive(bus.en, scan_step_s[SEL_W-1:0]);
                        end else begin
                            cnt_r    <= '0;
                            state_r  <= ST_IDLE;
                            active_r <= 1'b0;
                            out_r    <= OFF_PAT;
                        end
                    end
                    ST_SWEEP: begin
                        if (!dwell_end_s) begin
                            cnt_r <= cnt_r + DW_ONE;
                            out_r <= drive(bus.en, idx_r);
                        end else if (sweep_step_s[SEL_W]) begin
                            cnt_r <= '0;
                            idx_r <= sweep_step_s[SEL_W-1:0];
                            out_r <= drive(bus.en, sweep_step_s[SEL_W-1:0]);
                        end else begin
                            cnt_r    <= '0;
                            state_r  <= ST_IDLE;
                            active_r <= 1'b0;
                            out_r    <= OFF_PAT;
                            done_r   <= 1'b1;
                        end
                    end
                    default: begin
                        out_r <= OFF_PAT;
                    end
                endcase
            end
        end
    end
endmodule
